// File: rtl/cmos_dac_ctrl.sv
// cmos_dac_ctrl: DAC reset/init sequencer, 4-wire SPI register access and sample formatter.
// Define DAC_CTRL_INIT_VERIFY_EN to read back every init table entry and flag mismatches.
`timescale 1ns/1ps

module cmos_dac_ctrl #(
  parameter int unsigned NUM_CH      = 2,
  parameter int unsigned IN_W        = 16,
  parameter int unsigned DAC_W       = 14,
  parameter int unsigned ADDR_W      = 5,
  parameter int unsigned REG_W       = 8,
  parameter int unsigned SPI_CLK_DIV = 5,
  parameter int unsigned RST_CYCLES  = 255,
  parameter int unsigned INIT_LEN    = 1,
  parameter logic [INIT_LEN*(ADDR_W+REG_W)-1:0] INIT_TABLE = {5'h05, 8'h00},
  parameter logic [7:0]  CMD_PAGE    = 8'h20,
  parameter bit          OFFSET_BIN  = 1'b0
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic                    cmd_trig_in,
  input  logic [15:0]             cmd_addr_in,
  input  logic [15:0]             cmd_data_in,
  output logic [15:0]             cmd_data_out,
  output logic                    cmd_busy_out,
  output logic                    cmd_done_out,
  output logic                    cmd_drop_out,
  output logic                    init_done_out,
  output logic                    init_err_out,
  output logic                    dac_rst_out,
  output logic                    spi_scs_out,
  output logic                    spi_sck_out,
  output logic                    spi_sdo_out,
  input  logic                    spi_sdi_in,
  input  logic [NUM_CH*IN_W-1:0]  dac_in,
  output logic [NUM_CH*DAC_W-1:0] dac_out,
  output logic                    dac_valid_out
);

`ifdef DAC_CTRL_INIT_VERIFY_EN
  localparam bit VerifyEn = 1'b1;
`else
  localparam bit VerifyEn = 1'b0;
`endif

  localparam int unsigned EntryW = ADDR_W + REG_W;
  localparam int unsigned FrameW = 3 + ADDR_W + REG_W;
  localparam int unsigned CntMax = (RST_CYCLES > 2 * SPI_CLK_DIV) ? RST_CYCLES : 2 * SPI_CLK_DIV;
  localparam int unsigned CntW   = $clog2(CntMax + 1);
  localparam int unsigned IdxW   = (INIT_LEN > 1) ? $clog2(INIT_LEN) : 1;
  localparam int unsigned DivW   = $clog2(2 * SPI_CLK_DIV);
  localparam int unsigned BitW   = $clog2(FrameW);
  localparam logic [7:0]  CmdPageSet = CMD_PAGE + 8'd1;
  localparam logic [DAC_W-1:0] MidCode = {OFFSET_BIN, {(DAC_W-1){1'b0}}};

  typedef enum logic [2:0] {
    StRstHold, StRstRel, StInitWr, StInitRd, StIdle, StGet, StSet, StDone
  } state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic              frame_start, frame_rw, frame_cmd, frame_done;
  logic [FrameW-1:0] frame_word;
  logic [EntryW-1:0] entry;
  logic              page_get, page_set, init_last;
  logic [15:0]       cmd_data_q;
  logic              drop_q;

  // SPI engine state
  logic              spi_act_q, spi_gap_q, spi_sck_q, spi_scs_q, spi_sdo_q, spi_done_q;
  logic [DivW-1:0]   spi_div_q;
  logic [BitW-1:0]   spi_bit_q;
  logic [FrameW-1:0] spi_shift_q;
  logic [REG_W-1:0]  spi_rx_q;

  // Data path
  logic [NUM_CH*IN_W-1:0]  in_q;
  logic [NUM_CH*DAC_W-1:0] out_q, codes;
  logic                    valid_q, in_lsbs;
  logic                    unused_bits;

  assign page_get   = (cmd_addr_in[15:8] == CMD_PAGE);
  assign page_set   = (cmd_addr_in[15:8] == CmdPageSet);
  assign init_last  = (idx_q == IdxW'(INIT_LEN - 1));
  assign frame_done = spi_done_q;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q <= StRstHold;
      cnt_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    frame_start = 1'b0;
    frame_rw    = 1'b0;
    frame_cmd   = 1'b0;
    unique case (state_q)
      StRstHold: begin
        if (cnt_q == CntW'(RST_CYCLES - 1)) begin
          state_d = StRstRel;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StRstRel: begin
        if (cnt_q == CntW'(2 * SPI_CLK_DIV - 1)) begin
          state_d     = StInitWr;
          cnt_d       = '0;
          idx_d       = '0;
          frame_start = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StInitWr: begin
        if (frame_done) begin
          if (VerifyEn) begin
            state_d     = StInitRd;
            frame_start = 1'b1;
            frame_rw    = 1'b1;
          end else if (init_last) begin
            state_d = StIdle;
          end else begin
            idx_d       = idx_q + 1'b1;
            frame_start = 1'b1;
          end
        end
      end
      StInitRd: begin
        if (frame_done) begin
          if (init_last) begin
            state_d = StIdle;
          end else begin
            state_d     = StInitWr;
            idx_d       = idx_q + 1'b1;
            frame_start = 1'b1;
          end
        end
      end
      StIdle: begin
        if (cmd_trig_in && (page_get || page_set)) begin
          state_d     = page_get ? StGet : StSet;
          frame_start = 1'b1;
          frame_cmd   = 1'b1;
          frame_rw    = page_get;
        end
      end
      StGet, StSet: begin
        if (frame_done) state_d = StDone;
      end
      StDone:  state_d = StIdle;
      default: state_d = StRstHold;
    endcase

    // Frame content is captured by the SPI engine on frame_start, so no command latch is needed.
    entry = INIT_TABLE[EntryW * int'(idx_d) +: EntryW];
    if (frame_cmd) begin
      frame_word = {frame_rw, 2'b00, cmd_addr_in[ADDR_W-1:0],
                    frame_rw ? {REG_W{1'b0}} : cmd_data_in[REG_W-1:0]};
    end else begin
      frame_word = {frame_rw, 2'b00, entry[EntryW-1 -: ADDR_W],
                    frame_rw ? {REG_W{1'b0}} : entry[REG_W-1:0]};
    end
  end

  always_comb begin
    dac_rst_out   = (state_q == StRstHold);
    cmd_busy_out  = (state_q != StIdle);
    cmd_done_out  = (state_q == StDone);
    init_done_out = (state_q inside {StIdle, StGet, StSet, StDone});
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      cmd_data_q <= '0;
      drop_q     <= 1'b0;
    end else begin
      drop_q <= cmd_trig_in && (page_get || page_set) && (state_q != StIdle);
      if (state_q == StGet && frame_done) cmd_data_q <= {{(16-REG_W){1'b0}}, spi_rx_q};
    end
  end

`ifdef DAC_CTRL_INIT_VERIFY_EN
  logic             err_q;
  logic [REG_W-1:0] cur_data;
  assign cur_data = INIT_TABLE[EntryW * int'(idx_q) +: REG_W];

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      err_q <= 1'b0;
    end else if (state_q == StInitRd && frame_done && spi_rx_q != cur_data) begin
      err_q <= 1'b1;
    end
  end
  assign init_err_out = err_q;
`else
  assign init_err_out = 1'b0;
`endif

  // SPI mode 0: SDO moves on SCK fall, SDI sampled as SCK rises; SCS held high for a gap afterwards.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      spi_act_q   <= 1'b0;
      spi_gap_q   <= 1'b0;
      spi_sck_q   <= 1'b0;
      spi_scs_q   <= 1'b1;
      spi_sdo_q   <= 1'b0;
      spi_done_q  <= 1'b0;
      spi_div_q   <= '0;
      spi_bit_q   <= '0;
      spi_shift_q <= '0;
      spi_rx_q    <= '0;
    end else begin
      spi_done_q <= 1'b0;
      if (frame_start) begin
        spi_act_q   <= 1'b1;
        spi_scs_q   <= 1'b0;
        spi_sdo_q   <= frame_word[FrameW-1];
        spi_shift_q <= frame_word << 1;
        spi_div_q   <= '0;
        spi_bit_q   <= '0;
      end else if (spi_act_q) begin
        if (spi_div_q == DivW'(SPI_CLK_DIV - 1)) begin
          spi_div_q <= '0;
          if (!spi_sck_q) begin
            spi_sck_q <= 1'b1;
            spi_rx_q  <= {spi_rx_q[REG_W-2:0], spi_sdi_in};
          end else begin
            spi_sck_q <= 1'b0;
            if (spi_bit_q == BitW'(FrameW - 1)) begin
              spi_act_q <= 1'b0;
              spi_gap_q <= 1'b1;
              spi_scs_q <= 1'b1;
            end else begin
              spi_bit_q   <= spi_bit_q + 1'b1;
              spi_sdo_q   <= spi_shift_q[FrameW-1];
              spi_shift_q <= spi_shift_q << 1;
            end
          end
        end else begin
          spi_div_q <= spi_div_q + 1'b1;
        end
      end else if (spi_gap_q) begin
        if (spi_div_q == DivW'(2 * SPI_CLK_DIV - 1)) begin
          spi_div_q  <= '0;
          spi_gap_q  <= 1'b0;
          spi_done_q <= 1'b1;
        end else begin
          spi_div_q <= spi_div_q + 1'b1;
        end
      end
    end
  end

  // Keeping the top DAC_W bits is an arithmetic shift that truncates toward -inf.
  always_comb begin
    codes   = '0;
    in_lsbs = 1'b0;
    for (int c = 0; c < NUM_CH; c++) begin
      codes[c*DAC_W +: DAC_W] = in_q[c*IN_W + (IN_W - DAC_W) +: DAC_W] ^ MidCode;
      in_lsbs = in_lsbs ^ (^in_q[c*IN_W +: (IN_W - DAC_W)]);
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      in_q    <= '0;
      out_q   <= {NUM_CH{MidCode}};
      valid_q <= 1'b0;
    end else begin
      in_q    <= dac_in;
      out_q   <= init_done_out ? codes : {NUM_CH{MidCode}};
      valid_q <= init_done_out;
    end
  end

  assign unused_bits   = ^{cmd_addr_in[7:ADDR_W], cmd_data_in[15:REG_W], in_lsbs};
  assign cmd_data_out  = cmd_data_q;
  assign cmd_drop_out  = drop_q;
  assign spi_scs_out   = spi_scs_q;
  assign spi_sck_out   = spi_sck_q;
  assign spi_sdo_out   = spi_sdo_q;
  assign dac_out       = out_q;
  assign dac_valid_out = valid_q;

endmodule

// File: tb/tb_cmos_dac_ctrl.sv
// Bench for cmos_dac_ctrl: SPI slave DAC model, spec-level expectations, random data path and
// register traffic. Honours DAC_CTRL_INIT_VERIFY_EN when the build defines it.
`timescale 1ns/1ps

module tb_cmos_dac_ctrl;

`ifdef DAC_CTRL_INIT_VERIFY_EN
  localparam bit ForceBad = 1'b1;
  localparam logic ExpErr = 1'b1;
`else
  localparam bit ForceBad = 1'b0;
  localparam logic ExpErr = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_trig;
  logic [15:0] cmd_addr, cmd_wdata, cmd_rdata;
  logic        cmd_busy, cmd_done, cmd_drop, init_done, init_err, dac_rst;
  logic        spi_scs, spi_sck, spi_sdo, spi_sdi;
  logic [31:0] dac_in;
  logic [27:0] dac_out, dac_out_ob;
  logic        dac_valid, ob_valid;
  logic [15:0] ob_rdata;
  logic        ob_busy, ob_done, ob_drop, ob_init_done, ob_err, ob_rst, ob_scs, ob_sck, ob_sdo;

  always #5 clk = ~clk;

  cmos_dac_ctrl #(.SPI_CLK_DIV(10)) dut (
    .clk_in(clk), .rst_in(rst), .cmd_trig_in(cmd_trig), .cmd_addr_in(cmd_addr),
    .cmd_data_in(cmd_wdata), .cmd_data_out(cmd_rdata), .cmd_busy_out(cmd_busy),
    .cmd_done_out(cmd_done), .cmd_drop_out(cmd_drop), .init_done_out(init_done),
    .init_err_out(init_err), .dac_rst_out(dac_rst), .spi_scs_out(spi_scs),
    .spi_sck_out(spi_sck), .spi_sdo_out(spi_sdo), .spi_sdi_in(spi_sdi),
    .dac_in(dac_in), .dac_out(dac_out), .dac_valid_out(dac_valid)
  );

  cmos_dac_ctrl #(.SPI_CLK_DIV(10), .OFFSET_BIN(1'b1)) dut_ob (
    .clk_in(clk), .rst_in(rst), .cmd_trig_in(cmd_trig), .cmd_addr_in(cmd_addr),
    .cmd_data_in(cmd_wdata), .cmd_data_out(ob_rdata), .cmd_busy_out(ob_busy),
    .cmd_done_out(ob_done), .cmd_drop_out(ob_drop), .init_done_out(ob_init_done),
    .init_err_out(ob_err), .dac_rst_out(ob_rst), .spi_scs_out(ob_scs),
    .spi_sck_out(ob_sck), .spi_sdo_out(ob_sdo), .spi_sdi_in(1'b0),
    .dac_in(dac_in), .dac_out(dac_out_ob), .dac_valid_out(ob_valid)
  );

  int errors = 0;
  int checks = 0;

  // SPI slave model of the DAC register file
  logic [7:0]  regs [32];
  logic [15:0] frames_q [$];
  int          sl_bits;
  time         t_fall, t_r1, t_r2;

  initial begin
    logic [15:0] sh;
    logic [7:0]  rd;
    bit          aborted;
    time         tnow;
    for (int i = 0; i < 32; i++) regs[i] = 8'h00;
    regs[31] = 8'h3C;
    spi_sdi  = 1'b0;
    sl_bits  = 0;
    rd       = 8'h00;
    forever begin
      @(negedge spi_scs);
      t_fall  = $time;
      sl_bits = 0;
      sh      = 16'h0000;
      spi_sdi = 1'b0;
      aborted = 1'b0;
      for (int b = 0; b < 16 && !aborted; b++) begin
        @(posedge spi_sck or posedge spi_scs);
        tnow = $time;
        #1;
        if (spi_scs) begin
          aborted = 1'b1;
        end else begin
          sh = {sh[14:0], spi_sdo};
          sl_bits++;
          if (b == 0) t_r1 = tnow;
          if (b == 1) t_r2 = tnow;
          if (b < 15) begin
            @(negedge spi_sck or posedge spi_scs);
            #1;
            if (spi_scs) aborted = 1'b1;
            else if (sl_bits >= 8) begin
              if (sl_bits == 8)
                rd = !sh[7] ? 8'h00 : (ForceBad && sh[4:0] == 5'd5) ? 8'h01 : regs[sh[4:0]];
              else
                rd = rd << 1;
              spi_sdi = rd[7];
            end
          end
        end
      end
      if (!aborted) begin
        @(posedge spi_scs);
        frames_q.push_back(sh);
        if (!sh[15]) regs[sh[12:8]] = sh[7:0];
      end
    end
  end

  // Reference: signed sample divided by 4 rounding toward -inf, as a 14-bit code.
  function automatic logic [13:0] exp_code(input logic [15:0] x, input bit ob);
    int v, q;
    v = $signed(x);
    q = (v >= 0) ? v / 4 : -((-v + 3) / 4);
    if (ob) q = q + 8192;
    return 14'(q & 16383);
  endfunction

  function automatic logic [27:0] exp_pair(input logic [31:0] x, input bit ob);
    return {exp_code(x[31:16], ob), exp_code(x[15:0], ob)};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_frame(input string tag, input logic [15:0] exp);
    logic [15:0] got;
    if (frames_q.size() == 0) got = 16'hxxxx;
    else got = frames_q.pop_front();
    check(tag, {16'h0, got}, {16'h0, exp});
  endtask

  task automatic release_and_count(input string tag);
    int n;
    n = 0;
    @(negedge clk);
    rst = 1'b0;
    while (dac_rst === 1'b1 && n < 1000) begin
      n++;
      @(negedge clk);
    end
    check(tag, n, 255);
  endtask

  task automatic wait_init(input string tag);
    int n;
    n = 0;
    while (init_done !== 1'b1 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_done"}, init_done, 1'b1);
    check({tag, "_mid"}, dac_out, 28'h0);
    check({tag, "_valid0"}, dac_valid, 1'b0);
    check_frame({tag, "_wr"}, 16'h0500);
`ifdef DAC_CTRL_INIT_VERIFY_EN
    check_frame({tag, "_rd"}, 16'h8500);
`endif
    check({tag, "_nframes"}, frames_q.size(), 0);
    check({tag, "_err"}, init_err, ExpErr);
  endtask

  task automatic run_cmd(input string tag, input logic [15:0] a, input logic [15:0] d,
                         input bit poke, output logic [15:0] rdata);
    int n;
    @(negedge clk);
    cmd_trig = 1'b1; cmd_addr = a; cmd_wdata = d;
    @(negedge clk);
    cmd_trig = 1'b0; cmd_addr = 16'hFFFF; cmd_wdata = 16'($urandom);
    check({tag, "_busy"}, cmd_busy, 1'b1);
    if (poke) begin
      repeat (100) @(negedge clk);
      cmd_trig = 1'b1; cmd_addr = 16'h2107; cmd_wdata = 16'h0011;
      @(negedge clk);
      cmd_trig = 1'b0;
      check({tag, "_drop1"}, cmd_drop, 1'b1);
      @(negedge clk);
      check({tag, "_drop0"}, cmd_drop, 1'b0);
    end
    n = 0;
    while (cmd_done !== 1'b1 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_done"}, cmd_done, 1'b1);
    rdata = cmd_rdata;
    @(negedge clk);
    check({tag, "_done_pulse"}, cmd_done, 1'b0);
    check({tag, "_idle"}, cmd_busy, 1'b0);
  endtask

  initial begin
    logic [31:0] stim [$];
    logic [15:0] rdata;
    logic [4:0]  a;
    logic [7:0]  d;
    int          n;

    rst = 1'b1; cmd_trig = 1'b0; cmd_addr = 16'h0; cmd_wdata = 16'h0; dac_in = 32'h0;
    repeat (3) @(negedge clk);
    check("rst_dac_rst", dac_rst, 1'b1);
    check("rst_scs", spi_scs, 1'b1);
    check("rst_sck", spi_sck, 1'b0);
    check("rst_sdo", spi_sdo, 1'b0);
    check("rst_rdata", cmd_rdata, 16'h0);
    check("rst_busy", cmd_busy, 1'b1);
    check("rst_flags", {cmd_done, cmd_drop, init_done, init_err, dac_valid}, 5'b0);
    check("rst_dac_out", dac_out, 28'h0);
    check("rst_dac_out_ob", dac_out_ob, exp_pair(32'h0, 1'b1));

    release_and_count("rst_pulse");
    wait_init("init");
    check("bit_period", 32'(t_r2 - t_r1), 32'd200);
    check("sck_lead", 32'(t_r1 - t_fall), 32'd100);

    // Data path: directed corners then random samples, 2-cycle latency
    stim = {32'h8000_7FFF, 32'h0000_0000, 32'hFFFF_0001, 32'h0003_FFFC};
    for (int i = 0; i < 12; i++) stim.push_back($urandom);
    for (int i = 0; i < stim.size() + 2; i++) begin
      @(negedge clk);
      if (i >= 2) begin
        check($sformatf("dp_%0d", i - 2), dac_out, exp_pair(stim[i-2], 1'b0));
        check($sformatf("dp_ob_%0d", i - 2), dac_out_ob, exp_pair(stim[i-2], 1'b1));
        check("dp_valid", dac_valid, 1'b1);
      end
      if (i < stim.size()) dac_in = stim[i];
    end

    run_cmd("set", 16'h2103, 16'h00A5, 1'b1, rdata);
    check_frame("set_frame", 16'h03A5);
    check("set_rdata", rdata, 16'h0000);

    run_cmd("get", 16'h201F, 16'h1234, 1'b0, rdata);
    check_frame("get_frame", 16'h9F00);
    check("get_rdata", rdata, 16'h003C);

    for (int k = 0; k < 4; k++) begin
      a = 5'($urandom_range(0, 31));
      if (a == 5'd5) a = 5'd6;
      d = 8'($urandom_range(0, 255));
      run_cmd("rset", {8'h21, 3'b000, a}, {8'hEE, d}, 1'b0, rdata);
      check_frame("rset_frame", 16'(a) * 16'd256 + 16'(d));
      run_cmd("rget", {8'h20, 3'b000, a}, 16'h0000, 1'b0, rdata);
      check_frame("rget_frame", 16'h8000 + 16'(a) * 16'd256);
      check("rget_rdata", rdata, {8'h00, d});
    end

    @(negedge clk);
    cmd_trig = 1'b1; cmd_addr = 16'h5503;
    @(negedge clk);
    cmd_trig = 1'b0;
    check("badpage_busy", cmd_busy, 1'b0);
    check("badpage_drop", cmd_drop, 1'b0);
    repeat (30) @(negedge clk);
    check("badpage_scs", spi_scs, 1'b1);

    // Abort a frame mid-flight with reset
    @(negedge clk);
    cmd_trig = 1'b1; cmd_addr = 16'h2104; cmd_wdata = 16'h0077;
    @(negedge clk);
    cmd_trig = 1'b0;
    n = 0;
    while (!(spi_scs === 1'b0 && sl_bits >= 7) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("abort_reach_bit7", sl_bits, 7);
    #3 rst = 1'b1;
    #1;
    check("abort_scs", spi_scs, 1'b1);
    check("abort_sck", spi_sck, 1'b0);
    check("abort_dac_rst", dac_rst, 1'b1);
    check("abort_state", {cmd_busy, init_done, dac_valid}, 3'b100);
    check("abort_mid", dac_out_ob, exp_pair(32'h0, 1'b1));
    release_and_count("rst_pulse2");
    wait_init("reinit");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
